// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants and helpers for the serial pattern detectors
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W   = 16;

    // Mask with the low 'len' bits set; callers truncate to their pattern width (<= 64)
    function automatic logic [63:0] len_mask(input int len);
        return (len >= 64) ? '1 : (64'd1 << len) - 64'd1;
    endfunction

    // Lengths beyond the history depth behave as a full-depth pattern
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with sticky saturation flag and clear priority
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             sat
);

    // Count events until all-ones; flag is set by the increment that reaches all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            value <= '0;
            sat   <= 1'b0;
        end else if (inc && !(&value)) begin
            value <= value + 1'b1;
            sat   <= &(value + 1'b1);
        end
    end

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable serial pattern detector with match counter
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W,
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cnt_clr,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    logic [MAX_LEN-1:0] hist, hist_n, pat_q, mask;
    logic [LEN_W-1:0]   fill, fill_n, len_q;
    logic               ovl_q, accept, match;

    // Next history/fill and the match decision for the bit offered this cycle
    always_comb begin
        accept = in_valid && !cfg_load;
        hist_n = {hist[MAX_LEN-2:0], in_bit};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        mask   = MAX_LEN'(len_mask(int'(len_q)));
        match  = accept && (len_q != '0) && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
    end

    // Config load clears history; accepted bits shift in; non-overlap restarts fill on a match
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist     <= '0;
            fill     <= '0;
            pat_q    <= '0;
            len_q    <= '0;
            ovl_q    <= 1'b0;
            detected <= 1'b0;
        end else if (cfg_load) begin
            hist     <= '0;
            fill     <= '0;
            pat_q    <= cfg_pattern;
            len_q    <= LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));
            ovl_q    <= cfg_overlap;
            detected <= 1'b0;
        end else begin
            detected <= match;
            if (accept) begin
                hist <= hist_n;
                fill <= (match && !ovl_q) ? '0 : fill_n;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (cnt_clr),
        .value (match_count),
        .sat   (count_sat)
    );

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed and randomized checks against a queue-based reference model
module tb_seq_detector_prog;

    logic        clk = 1'b0;
    logic        rst, cfg_load, cfg_overlap, in_valid, in_bit, cnt_clr;
    logic [7:0]  cfg_pattern;
    logic [3:0]  cfg_len;
    logic        detected, detected2, count_sat, count_sat2;
    logic [15:0] match_count;
    logic [1:0]  match_count2;

    int checks = 0;
    int failures = 0;

    // Reference model: bits accepted since last clear, newest at the back
    logic        q[$];
    logic [7:0]  m_pat;
    int          m_len;
    logic        m_ovl;
    logic        exp_det;
    int          c16, c2;
    logic        s16, s2;

    seq_detector_prog dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .detected(detected),
        .match_count(match_count), .count_sat(count_sat)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid),
        .in_bit(in_bit), .cnt_clr(cnt_clr), .detected(detected2),
        .match_count(match_count2), .count_sat(count_sat2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".detected"}, 16'(detected), 16'(exp_det));
        check({tag, ".count"}, match_count, 16'(c16));
        check({tag, ".sat"}, 16'(count_sat), 16'(s16));
        check({tag, ".detected2"}, 16'(detected2), 16'(exp_det));
        check({tag, ".count2"}, 16'(match_count2), 16'(c2));
        check({tag, ".sat2"}, 16'(count_sat2), 16'(s2));
    endtask

    task automatic model_reset();
        q.delete();
        m_pat = '0; m_len = 0; m_ovl = 1'b0; exp_det = 1'b0;
        c16 = 0; c2 = 0; s16 = 1'b0; s2 = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic b, input logic ld, input logic clr,
                              input logic [7:0] p, input logic [3:0] l, input logic o);
        logic hit;
        hit = 1'b0;
        if (ld) begin
            m_pat = p;
            m_len = (int'(l) > 8) ? 8 : int'(l);
            m_ovl = o;
            q.delete();
        end else if (v) begin
            q.push_back(b);
            if (q.size() > 8) void'(q.pop_front());
            hit = (m_len != 0) && (q.size() >= m_len);
            for (int i = 0; i < m_len && hit; i++)
                if (q[q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
            if (hit && !m_ovl) q.delete();
        end
        exp_det = hit;
        if (clr) begin
            c16 = 0; c2 = 0; s16 = 1'b0; s2 = 1'b0;
        end else if (hit) begin
            if (c16 < 65535) c16++;
            if (c2 < 3) c2++;
            if (c16 == 65535) s16 = 1'b1;
            if (c2 == 3) s2 = 1'b1;
        end
    endtask

    task automatic cyc(input string tag, input logic v, input logic b,
                       input logic ld = 1'b0, input logic clr = 1'b0,
                       input logic [7:0] p = 8'h00, input logic [3:0] l = 4'd0, input logic o = 1'b0);
        in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        model_step(v, b, ld, clr, p, l, o);
        @(posedge clk);
        #1;
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
        check_all(tag);
    endtask

    task automatic send_bits(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(tag, 1'b1, bits[i]);
    endtask

    initial begin
        logic [7:0] a5;
        rst = 1'b1; cfg_load = 1'b0; cfg_overlap = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
        cnt_clr = 1'b0; cfg_pattern = '0; cfg_len = '0;
        model_reset();
        #12;
        check_all("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // 101 overlapping: pulses after 3rd and 5th bits
        cyc("ld_ovl", 1'b0, 1'b0, 1'b1, 1'b0, 8'b101, 4'd3, 1'b1);
        send_bits("ovl", 8'b10101, 5);
        cyc("ovl_idle", 1'b0, 1'b0);
        check("ovl_count", match_count, 16'd2);

        // 101 non-overlapping: single pulse
        cyc("clr", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("ld_novl", 1'b0, 1'b0, 1'b1, 1'b0, 8'b101, 4'd3, 1'b0);
        send_bits("novl", 8'b10101, 5);
        check("novl_count", match_count, 16'd1);

        // A5 len 8 with valid gaps
        cyc("ld_a5", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 4'd8, 1'b1);
        a5 = 8'hA5;
        for (int i = 7; i >= 0; i--) begin
            cyc("a5_bit", 1'b1, a5[i]);
            for (int g = $urandom_range(0, 3); g > 0; g--) cyc("a5_gap", 1'b0, 1'b1);
        end
        cyc("a5_after", 1'b0, 1'b0);

        // Load with simultaneous valid bit drops the bit and clears history
        cyc("clr2", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("ld_101", 1'b0, 1'b0, 1'b1, 1'b0, 8'b101, 4'd3, 1'b1);
        send_bits("pre", 8'b10, 2);
        cyc("ld_prio", 1'b1, 1'b1, 1'b1, 1'b0, 8'b01, 4'd2, 1'b1);
        send_bits("post", 8'b01, 2);
        check("post_count", match_count, 16'd1);

        // Saturation on the 2-bit counter, clear coincident with a match
        cyc("clr3", 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("ld_one", 1'b0, 1'b0, 1'b1, 1'b0, 8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 4; i++) cyc("sat", 1'b1, 1'b1);
        check("sat_flag2", 16'(count_sat2), 16'd1);
        cyc("sat_clr", 1'b1, 1'b1, 1'b0, 1'b1);
        check("sat_clr_count2", 16'(match_count2), 16'd0);

        // Clamp: len 12 behaves as len 8
        cyc("ld_clamp", 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 4'd12, 1'b0);
        send_bits("clamp", 8'hC3, 8);
        cyc("clamp_idle", 1'b0, 1'b0);

        // Randomized stream with occasional reconfiguration and clears
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                cyc("rnd_ld", 1'($urandom), 1'($urandom), 1'b1, 1'($urandom_range(0, 9) == 0),
                    8'($urandom),
                    ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 12)) : 4'($urandom_range(1, 3)),
                    1'($urandom));
            end else begin
                cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0,
                    1'($urandom_range(0, 49) == 0));
            end
        end

        // Reset in the cycle the completing bit is accepted
        cyc("ld_rst", 1'b0, 1'b0, 1'b1, 1'b0, 8'b101, 4'd3, 1'b1);
        send_bits("rst_pre", 8'b10, 2);
        in_valid = 1'b1; in_bit = 1'b1;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all("rst_mid");
        in_valid = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk); #1;
        send_bits("disabled", 8'b101, 3);
        send_bits("disabled2", 8'b101, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
